i2c_slave_rx: RTL and testbench

// - I2C target (slave) receiver: the responder to the I2C_1 master write engine.
// - Oversamples SCL/SDA on CLK and detects START/STOP.
// - Matches the 7-bit address, ACKs, then receives data bytes and ACKs each one.
// - Presents each byte on a parallel port with a one-cycle valid strobe.
// - Sits on the shared open-drain bus; the bus pull-up is external.

---
 rtl/i2c_slave_rx.sv | 168 ++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_rx
// Description : I2C target (slave) write receiver. Oversamples SCL/SDA on CLK,
//               detects START/STOP, matches a 7-bit address, ACKs it, then
//               receives data bytes and ACKs each one. Every received byte is
//               presented on data_out with a one-CLK data_valid strobe.
// Ports       : CLK        - system clock
//               RST_N      - asynchronous active-low reset
//               SCL        - raw bus clock from the master
//               SDA        - open-drain bus data (driven only 0 or z)
//               data_out   - last complete data byte received
//               data_valid - one-CLK pulse when data_out updates
//               addr_match - transaction addressed to this target is active
//               busy       - bus is between a START and a STOP
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       addr_match,
  output logic       busy
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_ADDR     = 3'd1;
  localparam logic [2:0] c_ADDR_ACK = 3'd2;
  localparam logic [2:0] c_DATA     = 3'd3;
  localparam logic [2:0] c_DATA_ACK = 3'd4;
  localparam logic [2:0] c_IGNORE   = 3'd5;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  logic [2:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_sda_low;
  logic [7:0] r_data_out;
  logic       r_data_valid;
  logic       r_addr_match;
  logic       r_busy;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_byte_done;

  // The only bus drive: pull low or release to the external pull-up.
  assign SDA = r_sda_low ? 1'b0 : 1'bz;

  // Synchronisers preset to 1 so an idle (pulled-up) bus never looks like an
  // edge coming out of reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high on both samples so an SDA change coinciding with an SCL
  // edge is not mistaken for a bus condition.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= c_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_sda_low    <= 1'b0;
      r_data_out   <= 8'd0;
      r_data_valid <= 1'b0;
      r_addr_match <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (r_state == c_IDLE) begin
        if (w_start) begin
          r_state   <= c_ADDR;
          r_bit_cnt <= 4'd0;
          r_busy    <= 1'b1;
        end
      end else if (w_stop) begin
        r_state      <= c_IDLE;
        r_sda_low    <= 1'b0;
        r_addr_match <= 1'b0;
        r_busy       <= 1'b0;
      end else if (w_start) begin
        // Repeated START: any partially shifted byte is simply abandoned.
        r_state      <= c_ADDR;
        r_bit_cnt    <= 4'd0;
        r_sda_low    <= 1'b0;
        r_addr_match <= 1'b0;
      end else begin
        case (r_state)
          c_ADDR, c_DATA: begin
            if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_byte_done) begin
              if (r_state == c_ADDR) begin
                if ((r_shift[7:1] == SLAVE_ADDR) && !r_shift[0]) begin
                  r_state      <= c_ADDR_ACK;
                  r_sda_low    <= 1'b1;
                  r_addr_match <= 1'b1;
                end else begin
                  r_state <= c_IGNORE;
                end
              end else begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
                r_sda_low    <= 1'b1;
                r_state      <= c_DATA_ACK;
              end
            end
          end
          c_ADDR_ACK, c_DATA_ACK: begin
            // ACK is held through the 9th high phase and dropped on its fall.
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= c_DATA;
            end
          end
          c_IGNORE: begin
            r_sda_low <= 1'b0;
          end
          default: begin
            r_state   <= c_IDLE;
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign addr_match = r_addr_match;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_rx
// Description : Directed bench for i2c_slave_rx. A bit-banged I2C write master
//               with a pull-up on SDA drives the target; received bytes are
//               collected by a monitor and compared with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rx;

  localparam int c_PH = 8;  // CLK cycles per SCL phase

  logic       clk;
  logic       rst_n;
  logic       r_scl;
  logic       r_m_sda;     // master SDA: 0 = drive low, 1 = release
  wire        sda;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addr_match;
  logic       busy;

  int         n_checks;
  int         n_errors;
  logic [7:0] rx_q[$];
  int         n_valid_long;
  int         n_dut_low;
  logic       r_valid_prev;
  logic       ack;

  assign sda = r_m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave_rx #(
    .SLAVE_ADDR  (7'h50),
    .SYNC_STAGES (2)
  ) u_dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .SCL        (r_scl),
    .SDA        (sda),
    .data_out   (data_out),
    .data_valid (data_valid),
    .addr_match (addr_match),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect strobed bytes; flag strobes longer than one cycle; count cycles
  // where SDA is low while the master has released it (target drive).
  always @(negedge clk) begin
    if (data_valid) rx_q.push_back(data_out);
    if (data_valid && r_valid_prev) n_valid_long++;
    r_valid_prev = data_valid;
    if (r_m_sda && (sda == 1'b0)) n_dut_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    r_m_sda = 1'b1; wait_clk(c_PH);
    r_scl   = 1'b1; wait_clk(c_PH);
    r_m_sda = 1'b0; wait_clk(c_PH);
    r_scl   = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_stop();
    r_m_sda = 1'b0; wait_clk(c_PH);
    r_scl   = 1'b1; wait_clk(c_PH);
    r_m_sda = 1'b1; wait_clk(c_PH);
  endtask

  task automatic i2c_bit(input logic b);
    r_m_sda = b;    wait_clk(c_PH);
    r_scl   = 1'b1; wait_clk(c_PH);
    r_scl   = 1'b0; wait_clk(2);
  endtask

  task automatic i2c_byte(input logic [7:0] v, output logic a);
    for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
    r_m_sda = 1'b1; wait_clk(c_PH);
    r_scl   = 1'b1; wait_clk(c_PH / 2);
    a = sda;        wait_clk(c_PH / 2);
    r_scl   = 1'b0; wait_clk(2);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_valid_long = 0; n_dut_low = 0;
    r_valid_prev = 1'b0;
    r_scl = 1'b1; r_m_sda = 1'b1; rst_n = 1'b0;
    wait_clk(5);
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_valid", {31'd0, data_valid}, 0);
    check("rst_addr_match", {31'd0, addr_match}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_sda", {31'd0, sda}, 1);
    rst_n = 1'b1;
    wait_clk(5);

    // 1: single byte write to our address
    rx_q.delete();
    i2c_start();
    check("t1_busy", {31'd0, busy}, 1);
    i2c_byte(8'hA0, ack);
    check("t1_addr_ack", {31'd0, ack}, 0);
    check("t1_addr_match", {31'd0, addr_match}, 1);
    i2c_byte(8'hAA, ack);
    check("t1_data_ack", {31'd0, ack}, 0);
    i2c_stop();
    check("t1_busy_after_stop", {31'd0, busy}, 0);
    check("t1_match_after_stop", {31'd0, addr_match}, 0);
    check("t1_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t1_byte", {24'd0, rx_q[0]}, 32'hAA);
    check("t1_data_out", {24'd0, data_out}, 32'hAA);

    // 2: wrong address
    rx_q.delete();
    i2c_start();
    i2c_byte(8'hA2, ack);
    check("t2_addr_nack", {31'd0, ack}, 1);
    check("t2_addr_match", {31'd0, addr_match}, 0);
    i2c_byte(8'h55, ack);
    check("t2_data_nack", {31'd0, ack}, 1);
    i2c_stop();
    check("t2_count", rx_q.size(), 0);

    // 3: three back-to-back bytes
    rx_q.delete();
    i2c_start();
    i2c_byte(8'hA0, ack);
    check("t3_addr_ack", {31'd0, ack}, 0);
    i2c_byte(8'h12, ack);
    check("t3_ack0", {31'd0, ack}, 0);
    i2c_byte(8'h34, ack);
    check("t3_ack1", {31'd0, ack}, 0);
    i2c_byte(8'hC3, ack);
    check("t3_ack2", {31'd0, ack}, 0);
    i2c_stop();
    check("t3_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("t3_byte0", {24'd0, rx_q[0]}, 32'h12);
      check("t3_byte1", {24'd0, rx_q[1]}, 32'h34);
      check("t3_byte2", {24'd0, rx_q[2]}, 32'hC3);
    end

    // 4: read request is refused
    rx_q.delete();
    n_dut_low = 0;
    i2c_start();
    i2c_byte(8'hA1, ack);
    check("t4_nack", {31'd0, ack}, 1);
    check("t4_addr_match", {31'd0, addr_match}, 0);
    check("t4_busy", {31'd0, busy}, 1);
    i2c_byte(8'hFF, ack);
    check("t4_nack2", {31'd0, ack}, 1);
    check("t4_sda_never_low", n_dut_low, 0);
    i2c_stop();
    check("t4_busy_after_stop", {31'd0, busy}, 0);
    check("t4_count", rx_q.size(), 0);

    // 5: repeated START after 4 data bits
    rx_q.delete();
    i2c_start();
    i2c_byte(8'hA0, ack);
    check("t5_addr_ack", {31'd0, ack}, 0);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b1);
    i2c_start();
    check("t5_match_cleared", {31'd0, addr_match}, 0);
    check("t5_busy_kept", {31'd0, busy}, 1);
    i2c_byte(8'hA0, ack);
    check("t5_addr_ack2", {31'd0, ack}, 0);
    i2c_byte(8'h5A, ack);
    check("t5_data_ack", {31'd0, ack}, 0);
    i2c_stop();
    check("t5_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t5_byte", {24'd0, rx_q[0]}, 32'h5A);

    // 6: reset asserted while the target holds the data ACK
    rx_q.delete();
    i2c_start();
    i2c_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) i2c_bit(logic'((8'hAA >> i) & 8'h01));
    r_m_sda = 1'b1; wait_clk(c_PH);
    r_scl   = 1'b1; wait_clk(c_PH / 2);
    check("t6_ack_held", {31'd0, sda}, 0);
    rst_n = 1'b0;
    #1;
    check("t6_sda_released", {31'd0, sda}, 1);
    check("t6_data_out", {24'd0, data_out}, 32'h00);
    check("t6_addr_match", {31'd0, addr_match}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_valid", {31'd0, data_valid}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(c_PH);
    r_scl = 1'b0; wait_clk(c_PH);
    rx_q.delete();
    i2c_start();
    i2c_byte(8'hA0, ack);
    check("t6_addr_ack", {31'd0, ack}, 0);
    i2c_byte(8'hAA, ack);
    check("t6_data_ack", {31'd0, ack}, 0);
    i2c_stop();
    check("t6_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t6_byte", {24'd0, rx_q[0]}, 32'hAA);

    check("valid_single_cycle", n_valid_long, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
